// File: rtl/sdram_test_pkg.sv
// Shared types and LFSR step function for the SDRAM traffic checker.
package sdram_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_NEXT    = 3'd4,
    ST_FIN     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    MODE_SEQ  = 2'd0,
    MODE_RAND = 2'd1,
    MODE_PAIR = 2'd2
  } mode_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Right-shifting Galois step: feedback taps are applied when the bit shifted out is 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/sdram_lfsr32.sv
// 32-bit Galois LFSR with synchronous load (priority) and step enable.
module sdram_lfsr32
  import sdram_test_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        step_i,
  output logic [31:0] state_o
);

  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i)      lfsr_d = load_val_i;
    else if (step_i) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/sdram_traffic_checker.sv
// On-chip write/readback traffic generator and checker for the byte-wide SDRAM
// controller request interface; bursts of LFSR data are written, replayed and compared.
module sdram_traffic_checker
  import sdram_test_pkg::*;
#(
  parameter int unsigned ADDR_DEPTH  = 24,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned BURST_LEN   = 4,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            mode,
  input  logic [15:0]           iterations,
  output logic [ADDR_DEPTH-1:0] addr_o,
  output logic [DATA_W-1:0]     data_wr,
  output logic                  wr,
  output logic                  rd,
  input  logic                  rdy,
  input  logic                  val,
  input  logic [DATA_W-1:0]     data_rd,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           err_count,
  output logic [ADDR_DEPTH-1:0] first_err_addr,
  output logic [DATA_W-1:0]     first_err_data,
  output logic [15:0]           iter_count
);

  localparam int unsigned     IDX_W    = $clog2(BURST_LEN);
  localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BURST_LEN - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [31:0]           seed_q, seed_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [15:0]           err_q, err_d;
  logic [15:0]           iter_q, iter_d;
  logic [ADDR_DEPTH-1:0] ferr_addr_q, ferr_addr_d;
  logic [DATA_W-1:0]     ferr_data_q, ferr_data_d;
  logic                  pass_q, pass_d;
  logic                  tflag_q, tflag_d;

  logic [31:0]           lfsr;
  logic                  lfsr_load, lfsr_step;
  logic [ADDR_DEPTH-1:0] ent_addr;
  logic [DATA_W-1:0]     ent_data;
  logic                  wr_acc, rd_val, ent_done, idx_last, expired, waiting;
  logic                  unused_bits;

  sdram_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (lfsr_load),
    .load_val_i (seed_q),
    .step_i     (lfsr_step),
    .state_o    (lfsr)
  );

  // Sequential mode takes its upper address bits from the burst seed, so the
  // whole burst stays in one aligned block; the others follow the live LFSR.
  always_comb begin
    if (mode_q == MODE_SEQ) ent_addr = {seed_q[ADDR_DEPTH-1:IDX_W], idx_q};
    else                    ent_addr = {lfsr[ADDR_DEPTH-1:IDX_W], idx_q};
    ent_data = lfsr[31 -: DATA_W];
    if (mode_q == MODE_PAIR && idx_q[0]) ent_data = ~ent_data;
  end

  assign wr_acc    = (state_q == ST_WR) && rdy;
  assign rd_val    = (state_q == ST_RD_WAIT) && val;
  assign ent_done  = wr_acc || rd_val;
  assign idx_last  = (idx_q == IDX_LAST);
  assign expired   = (tmo_q == TMO_LAST);
  assign waiting   = (state_q == ST_WR) || (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT);
  // Pair mode holds the LFSR on even entries so the odd partner reuses its value.
  assign lfsr_step = ent_done && ((mode_q != MODE_PAIR) || idx_q[0]);
  assign lfsr_load = wr_acc && idx_last;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    seed_d      = seed_q;
    err_d       = err_q;
    iter_d      = iter_q;
    ferr_addr_d = ferr_addr_q;
    ferr_data_d = ferr_data_q;
    pass_d      = pass_q;
    tflag_d     = tflag_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_WR;
          case (mode)
            2'd0:    mode_d = MODE_SEQ;
            2'd2:    mode_d = MODE_PAIR;
            default: mode_d = MODE_RAND;
          endcase
          seed_d      = lfsr;
          idx_d       = '0;
          err_d       = '0;
          iter_d      = '0;
          ferr_addr_d = '0;
          ferr_data_d = '0;
          pass_d      = 1'b0;
          tflag_d     = 1'b0;
        end
      end
      ST_WR: begin
        if (rdy) begin
          if (idx_last) begin
            idx_d   = '0;
            state_d = ST_RD_REQ;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (expired) begin
          state_d = ST_FIN;
          tflag_d = 1'b1;
          pass_d  = 1'b0;
        end
      end
      ST_RD_REQ: begin
        if (rdy) begin
          state_d = ST_RD_WAIT;
        end else if (expired) begin
          state_d = ST_FIN;
          tflag_d = 1'b1;
          pass_d  = 1'b0;
        end
      end
      ST_RD_WAIT: begin
        if (val) begin
          if (data_rd != ent_data) begin
            if (err_q == 16'd0) begin
              ferr_addr_d = ent_addr;
              ferr_data_d = data_rd;
            end
            err_d = sat_inc16(err_q);
          end
          if (idx_last) begin
            idx_d   = '0;
            state_d = ST_NEXT;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_RD_REQ;
          end
        end else if (expired) begin
          state_d = ST_FIN;
          tflag_d = 1'b1;
          pass_d  = 1'b0;
        end
      end
      ST_NEXT: begin
        iter_d = iter_q + 16'd1;
        seed_d = lfsr;
        idx_d  = '0;
        if (stop || ((iterations != 16'd0) && (iter_d == iterations))) begin
          state_d = ST_FIN;
          pass_d  = (err_q == 16'd0) && !tflag_q;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The wait counter restarts on every state change and on every accepted entry.
  always_comb begin
    tmo_d = '0;
    if (waiting && (state_d == state_q) && !ent_done) tmo_d = tmo_q + TMO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_SEQ;
      idx_q       <= '0;
      seed_q      <= LFSR_SEED;
      tmo_q       <= '0;
      err_q       <= '0;
      iter_q      <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
      pass_q      <= 1'b0;
      tflag_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      seed_q      <= seed_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      iter_q      <= iter_d;
      ferr_addr_q <= ferr_addr_d;
      ferr_data_q <= ferr_data_d;
      pass_q      <= pass_d;
      tflag_q     <= tflag_d;
    end
  end

  assign wr             = (state_q == ST_WR);
  assign rd             = (state_q == ST_RD_REQ);
  assign addr_o         = waiting ? ent_addr : '0;
  assign data_wr        = wr ? ent_data : '0;
  assign busy           = waiting || (state_q == ST_NEXT);
  assign done           = (state_q == ST_FIN);
  assign pass           = pass_q;
  assign timeout        = tflag_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_addr_q;
  assign first_err_data = ferr_data_q;
  assign iter_count     = iter_q;

  assign unused_bits = ^{lfsr, seed_q};

endmodule

// File: tb/tb_sdram_traffic_checker.sv
// Directed bench: byte-RAM responder behind the traffic checker, expected values from constants and a small LFSR model.
module tb_sdram_traffic_checker;

  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic        clk, rst_n, start, stop;
  logic [1:0]  mode;
  logic [15:0] iterations;
  logic [23:0] addr_o;
  logic [7:0]  data_wr, data_rd;
  logic        wr, rd, rdy, val;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count, iter_count;
  logic [23:0] first_err_addr;
  logic [7:0]  first_err_data;

  sdram_traffic_checker #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .iterations(iterations), .addr_o(addr_o), .data_wr(data_wr), .wr(wr), .rd(rd),
    .rdy(rdy), .val(val), .data_rd(data_rd), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr),
    .first_err_data(first_err_data), .iter_count(iter_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_lfsr(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Responder state; it owns all of these and clears them when test_id changes.
  int          test_id = 0, tid_seen = 0;
  int          corrupt_rd = -1;
  bit          hold_rdy = 1'b0;
  int          wr_num, rd_num, done_cnt, vcnt;
  bit          phase;
  logic [7:0]  rdat;
  logic [23:0] wa_log[$], ra_log[$];
  logic [7:0]  wd_log[$];
  logic [7:0]  mem [logic [23:0]];

  initial begin
    rdy = 1'b0; val = 1'b0; data_rd = 8'h00; phase = 1'b0;
    wr_num = 0; rd_num = 0; done_cnt = 0; vcnt = 0;
    forever begin
      @(negedge clk);
      if (tid_seen != test_id) begin
        tid_seen = test_id;
        wr_num = 0; rd_num = 0; done_cnt = 0; vcnt = 0;
        wa_log.delete(); wd_log.delete(); ra_log.delete(); mem.delete();
      end
      if (done) done_cnt++;
      val = 1'b0;
      if (vcnt > 0) begin
        vcnt--;
        if (vcnt == 0) val = 1'b1;
      end
      phase = ~phase;
      rdy = phase && !(hold_rdy && wr_num >= 1);
      if (rdy && wr) begin
        mem[addr_o] = data_wr;
        wa_log.push_back(addr_o);
        wd_log.push_back(data_wr);
        wr_num++;
      end
      if (rdy && rd) begin
        rdat = mem.exists(addr_o) ? mem[addr_o] : 8'h00;
        if (rd_num == corrupt_rd) rdat = rdat ^ 8'h01;
        data_rd = rdat;
        ra_log.push_back(addr_o);
        vcnt = 3;
        rd_num++;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic begin_run(input logic [1:0] md, input logic [15:0] it);
    test_id++;
    mode = md;
    iterations = it;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  // addrs/datas hold entry 0 in their most significant field.
  task automatic check_first4(input string tag, input logic [95:0] addrs, input logic [31:0] datas);
    if (wa_log.size() < 4) begin
      chk({tag, "_cnt"}, wa_log.size(), 4);
    end else begin
      for (int i = 0; i < 4; i++) begin
        chk({tag, "_a"}, wa_log[i], addrs[(3-i)*24 +: 24]);
        chk({tag, "_d"}, wd_log[i], datas[(3-i)*8 +: 8]);
      end
    end
  endtask

  task automatic check_model(input int md, input int nb);
    logic [31:0] s, sb;
    logic [23:0] ea;
    logic [7:0]  ed;
    int          k = 0;
    s = SEED;
    chk("m_wr_cnt", wa_log.size(), nb * 4);
    chk("m_rd_cnt", ra_log.size(), nb * 4);
    for (int b = 0; b < nb; b++) begin
      sb = s;
      for (int i = 0; i < 4; i++) begin
        ea = (md == 0) ? {sb[23:2], 2'(i)} : {s[23:2], 2'(i)};
        ed = s[31:24];
        if (md == 2 && (i % 2) == 1) ed = ~ed;
        if (k < wa_log.size()) begin
          chk("m_addr", wa_log[k], ea);
          chk("m_data", wd_log[k], ed);
        end
        if (k < ra_log.size()) chk("m_raddr", ra_log[k], ea);
        if (md != 2 || (i % 2) == 1) s = model_lfsr(s);
        k++;
      end
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0; iterations = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {26'd0, busy, done, pass, timeout, wr, rd}, 0);
    chk("rst_cnt", {err_count, iter_count}, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_ferr", {first_err_addr, first_err_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 0, three bursts, with a start pulse mid-run that must be ignored.
    begin_run(2'd0, 16'd3);
    n = 0;
    while (wr_num < 6 && n < 200) begin @(negedge clk); n++; end
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done(400);
    chk("seq_err", err_count, 0);
    chk("seq_iter", iter_count, 3);
    chk("seq_pass", pass, 1);
    chk("seq_tmo", timeout, 0);
    check_first4("seq_b0", {24'hE12468, 24'hE12469, 24'hE1246A, 24'hE1246B}, 32'hAC562B15);
    check_model(0, 3);
    repeat (4) @(negedge clk);
    chk("seq_done_pulses", done_cnt, 1);
    chk("seq_busy", busy, 0);

    // Mode 2 byte-pair.
    do_reset();
    begin_run(2'd2, 16'd3);
    wait_done(400);
    chk("pair_err", err_count, 0);
    chk("pair_pass", pass, 1);
    check_first4("pair_b0", {24'hE12468, 24'hE12469, 24'h709236, 24'h709237}, 32'hAC5356A9);
    check_model(2, 3);

    // Second read of the first burst corrupted.
    do_reset();
    corrupt_rd = 1;
    begin_run(2'd0, 16'd2);
    wait_done(400);
    chk("cor_err", err_count, 1);
    chk("cor_faddr", first_err_addr, 24'hE12469);
    chk("cor_fdata", first_err_data, 8'h57);
    chk("cor_pass", pass, 0);
    chk("cor_iter", iter_count, 2);
    corrupt_rd = -1;

    // rdy stuck low after the first write.
    do_reset();
    hold_rdy = 1'b1;
    begin_run(2'd0, 16'd3);
    n = 0;
    while (wr_num < 1 && n < 20) begin @(negedge clk); n++; end
    chk("tmo_first_wr", wr_num, 1);
    n = 0;
    while (!done && n < 18) begin @(negedge clk); n++; end
    chk("tmo_done_in_18", done, 1);
    chk("tmo_wr_low", {wr, rd}, 0);
    chk("tmo_flag", timeout, 1);
    chk("tmo_pass", pass, 0);
    chk("tmo_busy", busy, 0);
    hold_rdy = 1'b0;

    // Free-running with stop raised during burst 2.
    do_reset();
    begin_run(2'd1, 16'd0);
    n = 0;
    while (wr_num < 5 && n < 200) begin @(negedge clk); n++; end
    stop = 1'b1;
    wait_done(400);
    stop = 1'b0;
    chk("stop_iter", iter_count, 2);
    chk("stop_rd_num", rd_num, 8);
    chk("stop_pass", pass, 1);
    check_model(1, 2);

    // Asynchronous reset while a read request is pending.
    do_reset();
    corrupt_rd = 1;
    begin_run(2'd0, 16'd3);
    n = 0;
    while (!(rd_num >= 5 && rd) && n < 300) begin @(negedge clk); n++; end
    chk("ar_rd_pending", rd, 1);
    chk("ar_err_pre", err_count, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_wr_rd", {wr, rd}, 0);
    chk("ar_busy", busy, 0);
    chk("ar_err", err_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    corrupt_rd = -1;
    @(negedge clk);
    begin_run(2'd0, 16'd1);
    wait_done(200);
    check_first4("ar_b0", {24'hE12468, 24'hE12469, 24'hE1246A, 24'hE1246B}, 32'hAC562B15);
    chk("ar_pass", pass, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_traffic_checker.md
Name: sdram_traffic_checker

Overview:
- Synthesizable, self-checking traffic generator for the byte-wide SDRAM controller request interface (addr/wr/rd/rdy/val/data_rd).
- Writes a burst of BURST_LEN pseudo-random entries, replays the same LFSR sequence to read them back, compares each result, and repeats for a programmable number of iterations.
- Sits between a control/status source (UART or debug regs) and the controller; it replaces the bench-only stimulus with on-chip hardware test.

Parameters:
- ADDR_DEPTH, 24, controller address width (8..32).
- DATA_W, 8, controller data width (1..32).
- BURST_LEN, 4, entries per write/readback burst; power of two, 2..256.
- LFSR_SEED, 32'hACE1_2468, reset/start seed; must be nonzero.
- TIMEOUT_CYC, 1024, maximum cycles waiting for rdy or val.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a run when idle, ignored when busy.
- stop  in  1  level; ends the run at the next burst boundary.
- mode  in  2  0 sequential, 1 random, 2 byte-pair, 3 reserved (treated as 1); sampled at start.
- iterations  in  16  bursts to run; 0 means run until stop.
- addr_o  out  ADDR_DEPTH  request address.
- data_wr  out  DATA_W  write data.
- wr  out  1  write request.
- rd  out  1  read request.
- rdy  in  1  controller accepts the held request at this edge.
- val  in  1  data_rd valid.
- data_rd  in  DATA_W  read data.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run end.
- pass  out  1  sticky; last run had err_count==0 and no timeout.
- timeout  out  1  sticky; last run aborted on timeout.
- err_count  out  16  mismatches, saturating at 16'hFFFF.
- first_err_addr  out  ADDR_DEPTH  address of the first mismatch.
- first_err_data  out  DATA_W  data read at the first mismatch.
- iter_count  out  16  bursts completed.

Behaviour:
- Reset values: all outputs 0; LFSR=LFSR_SEED; state IDLE.
- LFSR: 32-bit Galois, taps 32'h8020_0003, advances one step per accepted entry. Data = lfsr[31 -: DATA_W]. IDX_W = log2(BURST_LEN).
- Address per mode:
  - Mode 0: base + idx, where base = {lfsr[ADDR_DEPTH-1:IDX_W], IDX_W'b0}, latched at burst start.
  - Mode 1: {lfsr[ADDR_DEPTH-1:IDX_W], idx}. The idx field keeps entries within a burst unique.
  - Mode 2: even idx uses {lfsr[ADDR_DEPTH-1:IDX_W], idx}, data D. Odd idx reuses the preceding upper bits with bit0=1 and data ~D. The LFSR advances only on odd idx.
- States: IDLE -> WR -> RD_REQ -> RD_WAIT -> (RD_REQ | NEXT) ; NEXT -> WR | FIN ; FIN -> IDLE.
- IDLE:
  - start clears err_count, first_err_*, iter_count, pass and timeout.
  - Latches mode; busy=1 on the next cycle; saves the LFSR state as burst_seed.
- WR:
  - wr=1 with addr/data of entry idx, held stable until the edge where rdy=1.
  - That edge advances idx/LFSR; the next entry is presented the following cycle, so back-to-back is allowed.
  - After entry BURST_LEN-1 is accepted: LFSR := burst_seed, idx := 0, go RD_REQ.
- RD_REQ: rd=1 held until rdy. At acceptance: rd=0, go RD_WAIT.
- RD_WAIT:
  - First val compares data_rd against the regenerated expected value.
  - On mismatch: err_count++ (saturating). If this is the first error, capture addr_o and data_rd.
  - Then advance idx/LFSR. After the last entry go NEXT, else RD_REQ.
- NEXT:
  - iter_count++. burst_seed := current LFSR, so the next burst continues the sequence.
  - Go FIN if stop=1 or iter_count+1 == iterations (iterations≠0); else WR.
- FIN: busy=0; done=1 for one cycle; pass := (err_count==0 && !timeout).
- wr and rd are never asserted together. No new request while in RD_WAIT.
- val outside RD_WAIT is ignored.
- Timeout: a counter resets on each state change. Reaching TIMEOUT_CYC in WR, RD_REQ or RD_WAIT drops wr/rd, sets timeout, and goes to FIN.
- start while busy is ignored. stop during IDLE has no effect.
- Reset mid-operation returns immediately to IDLE with wr=rd=0.

Decomposition:
- Package sdram_test_pkg holds:
  - state enum;
  - mode enum (MODE_SEQ, MODE_RAND, MODE_PAIR);
  - LFSR_TAPS constant;
  - function lfsr_next(logic [31:0]).
- One sub-module: sdram_lfsr32, which has load, load_val and step inputs and a state output.

Test Plan:
- Behavioural byte-RAM responder (rdy toggling every other cycle, val 3 cycles after read acceptance), mode 0, BURST_LEN=4, iterations=3 -> 12 writes, 12 reads, err_count=0, iter_count=3, pass=1, one done pulse.
- Same responder, mode 2 -> each burst contains address pairs differing only in bit0 with data D and ~D; all reads match; pass=1.
- Responder corrupts the second read of burst 1 by XOR 8'h01 -> err_count=1; first_err_addr equals the second write address; first_err_data = written^1; pass=0.
- Responder holds rdy=0 permanently after the first write, TIMEOUT_CYC=16 -> wr drops; timeout=1; done pulses within 18 cycles; pass=0.
- iterations=0, stop asserted mid-burst 2 -> burst 2 completes all 4 readbacks, then done; iter_count=2.
- rst_n asserted low while rd is pending -> rd and wr are 0 immediately (asynchronous), busy=0, err_count=0; a subsequent start reproduces identical addresses from LFSR_SEED.
